alu_bus_sequencer: RTL and testbench

Sequences one ALU operation over the shared single-word internal data bus. It accepts a command from the control unit and captures operand A, then operand B for binary ops, from the bus. It drives the combinational alu and registers the result for return to the bus. It owns the architectural flags register (C, Z, N) and feeds flag C back as the ALU carry-in.

---
 rtl/alu_bus_sequencer_pkg.sv | 45 ++++
 rtl/alu_bus_sequencer_alu.sv | 50 +++++
 rtl/alu_bus_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_bus_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_bus_sequencer_pkg.sv
// Shared types for the ALU bus sequencer: opcodes, sequencer states and
// opcode classification helpers.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_bus_sequencer_pkg;

    localparam int unsigned WORD_SIZE_DEFAULT = `WORD_SIZE;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_CMP = 4'd6,
        OP_INC = 4'd7,
        OP_DEC = 4'd8,
        OP_SHR = 4'd9,
        OP_SHL = 4'd10
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_A = 3'd1,
        WAIT_B = 3'd2,
        EXEC   = 3'd3,
        RESULT = 3'd4
    } seq_state_t;

    function automatic logic is_unary(opcode_t op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

    function automatic logic writes_c(opcode_t op);
        return op inside {OP_ADD, OP_ADC, OP_SUB};
    endfunction

    function automatic logic writes_zn(opcode_t op);
        return op inside {OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP};
    endfunction

endpackage

// File: rtl/alu_bus_sequencer_alu.sv
// Combinational ALU: result plus carry/borrow, zero and negative indications.
module alu
    import alu_bus_sequencer_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  opcode_t              opcode,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic                 carry_in,
    output logic [WORD_SIZE-1:0] out,
    output logic                 c_out,
    output logic                 z_out,
    output logic                 n_out
);

    localparam logic [WORD_SIZE-1:0] ONE       = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE:0]   SHIFT_LIM = (WORD_SIZE+1)'(WORD_SIZE);

    logic [WORD_SIZE:0] ext;
    logic               shift_oob;

    assign shift_oob = ({1'b0, b} >= SHIFT_LIM);

    always_comb begin
        ext   = '0;
        out   = '0;
        c_out = 1'b0;
        case (opcode)
            OP_ADD: ext = {1'b0, a} + {1'b0, b};
            OP_ADC: ext = {1'b0, a} + {1'b0, b} + {{WORD_SIZE{1'b0}}, carry_in};
            // Top bit of the widened difference is the borrow (a < b).
            OP_SUB: ext = {1'b0, a} - {1'b0, b};
            OP_AND: ext = {1'b0, a & b};
            OP_OR:  ext = {1'b0, a | b};
            OP_XOR: ext = {1'b0, a ^ b};
            OP_CMP: ext = {{WORD_SIZE{1'b0}}, (a == b)};
            OP_INC: ext = {1'b0, a + ONE};
            OP_DEC: ext = {1'b0, a - ONE};
            OP_SHR: ext = shift_oob ? '0 : {1'b0, a >> b};
            OP_SHL: ext = shift_oob ? '0 : {1'b0, a << b};
            default: ext = '0;
        endcase
        out   = ext[WORD_SIZE-1:0];
        c_out = ext[WORD_SIZE];
        z_out = (out == '0);
        n_out = out[WORD_SIZE-1];
    end

endmodule

// File: rtl/alu_bus_sequencer.sv
// Sequences one ALU operation over the shared data bus and owns the C/Z/N
// flags register; flag C feeds back as the ALU carry-in.
module alu_bus_sequencer
    import alu_bus_sequencer_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  opcode_t              cmd_opcode,
    input  logic                 cmd_flags_we,
    input  logic [WORD_SIZE-1:0] bus_in,
    input  logic                 bus_in_valid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORD_SIZE-1:0] bus_out,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_n
);

    seq_state_t           state, next_state;
    opcode_t              opcode_q;
    logic                 flags_we_q;
    logic [WORD_SIZE-1:0] a_q, b_q;
    logic                 latch_cmd, latch_a, latch_b, exec_en;

    logic [WORD_SIZE-1:0] alu_b, alu_out;
    logic                 alu_c, alu_z, alu_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        latch_cmd  = 1'b0;
        latch_a    = 1'b0;
        latch_b    = 1'b0;
        exec_en    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    latch_cmd  = 1'b1;
                    next_state = WAIT_A;
                end
            end
            WAIT_A: begin
                if (bus_in_valid) begin
                    latch_a    = 1'b1;
                    next_state = is_unary(opcode_q) ? EXEC : WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus_in_valid) begin
                    latch_b    = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                exec_en    = 1'b1;
                next_state = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q   <= OP_ADD;
            flags_we_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            bus_out    <= '0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
        end else begin
            if (latch_cmd) begin
                opcode_q   <= cmd_opcode;
                flags_we_q <= cmd_flags_we;
            end
            if (latch_a) a_q <= bus_in;
            if (latch_b) b_q <= bus_in;
            if (exec_en) begin
                bus_out <= alu_out;
                if (flags_we_q && writes_c(opcode_q)) flag_c <= alu_c;
                if (flags_we_q && writes_zn(opcode_q)) begin
                    flag_z <= alu_z;
                    flag_n <= alu_n;
                end
            end
        end
    end

    // Unary ops never load B, so force it to zero rather than leak a stale word.
    assign alu_b = is_unary(opcode_q) ? '0 : b_q;

    alu #(
        .WORD_SIZE(WORD_SIZE)
    ) u_alu (
        .opcode  (opcode_q),
        .a       (a_q),
        .b       (alu_b),
        .carry_in(flag_c),
        .out     (alu_out),
        .c_out   (alu_c),
        .z_out   (alu_z),
        .n_out   (alu_n)
    );

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Self-checking bench for alu_bus_sequencer: vector table with a result
// scoreboard, plus a hand-written reset-abort sequence.
module tb_alu_bus_sequencer;
    import alu_bus_sequencer_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    opcode_t      cmd_opcode;
    logic         cmd_flags_we;
    logic [W-1:0] bus_in;
    logic         bus_in_valid;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] bus_out;
    logic         flag_c, flag_z, flag_n;

    alu_bus_sequencer #(
        .WORD_SIZE(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_flags_we(cmd_flags_we),
        .bus_in      (bus_in),
        .bus_in_valid(bus_in_valid),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .bus_out     (bus_out),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .flag_n      (flag_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        opcode_t      op;
        logic         we;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           gap_a;
        int           gap_b;
        int           hold;
        logic         extra;
        logic [W-1:0] exp_out;
        logic [2:0]   exp_f;   // {C, Z, N}
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        logic [2:0]   f;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vec[19];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [2:0] flags();
        return {flag_c, flag_z, flag_n};
    endfunction

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input string tag, input vec_t v);
        sb_t exp;
        int  t0, w, lat;
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_opcode   = v.op;
        cmd_flags_we = v.we;
        t0 = cyc;
        sb_q.push_back('{v.exp_out, v.exp_f});
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (v.gap_a) begin
            bus_in_valid = 1'b0;
            @(negedge clk);
        end
        bus_in_valid = 1'b1;
        bus_in       = v.a;
        @(negedge clk);
        if (!is_unary(v.op)) begin
            repeat (v.gap_b) begin
                bus_in_valid = 1'b0;
                bus_in       = 8'hEE;
                @(negedge clk);
            end
            bus_in_valid = 1'b1;
            bus_in       = v.b;
            @(negedge clk);
        end
        bus_in_valid = v.extra;
        bus_in       = v.extra ? 8'h77 : 8'h00;
        w = 0;
        while (!res_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        bus_in_valid = 1'b0;
        chk({tag, " res_valid"}, res_valid, 1);
        lat = is_unary(v.op) ? 3 + v.gap_a : 4 + v.gap_a + v.gap_b;
        chk({tag, " latency"}, cyc - t0, lat);
        exp = sb_q.pop_front();
        chk({tag, " bus_out"}, bus_out, exp.out);
        chk({tag, " flags"}, flags(), exp.f);
        for (int i = 0; i < v.hold; i++) begin
            res_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("%s hold%0d res_valid", tag, i), res_valid, 1);
            chk($sformatf("%s hold%0d cmd_ready", tag, i), cmd_ready, 0);
            chk($sformatf("%s hold%0d bus_out", tag, i), bus_out, exp.out);
        end
        res_ready = 1'b1;
        chk({tag, " cmd_ready in handshake"}, cmd_ready, 0);
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, " res_valid after"}, res_valid, 0);
        chk({tag, " cmd_ready after"}, cmd_ready, 1);
        chk({tag, " flags after"}, flags(), exp.f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{OP_ADD, 1'b1, 8'hF0, 8'h20, 0, 0, 0, 1'b0, 8'h10, 3'b100};
        vec[1]  = '{OP_ADC, 1'b1, 8'h01, 8'h01, 0, 0, 0, 1'b0, 8'h03, 3'b000};
        vec[2]  = '{OP_SUB, 1'b1, 8'h05, 8'h05, 0, 0, 0, 1'b0, 8'h00, 3'b010};
        vec[3]  = '{OP_SUB, 1'b1, 8'h00, 8'h01, 0, 0, 1, 1'b0, 8'hFF, 3'b101};
        vec[4]  = '{OP_INC, 1'b1, 8'hFF, 8'h00, 0, 0, 0, 1'b1, 8'h00, 3'b101};
        vec[5]  = '{OP_ADD, 1'b0, 8'h80, 8'h80, 0, 0, 0, 1'b0, 8'h00, 3'b101};
        vec[6]  = '{OP_SHL, 1'b1, 8'h01, 8'h09, 2, 2, 3, 1'b0, 8'h00, 3'b101};
        vec[7]  = '{OP_ADC, 1'b1, 8'h7F, 8'h00, 1, 0, 0, 1'b0, 8'h80, 3'b001};
        vec[8]  = '{OP_CMP, 1'b1, 8'h5A, 8'h5A, 0, 1, 0, 1'b0, 8'h01, 3'b000};
        vec[9]  = '{OP_CMP, 1'b1, 8'h5A, 8'h5B, 0, 0, 0, 1'b0, 8'h00, 3'b010};
        vec[10] = '{OP_XOR, 1'b1, 8'hFF, 8'h0F, 0, 0, 0, 1'b0, 8'hF0, 3'b001};
        vec[11] = '{OP_AND, 1'b1, 8'hF0, 8'h0F, 0, 0, 0, 1'b0, 8'h00, 3'b010};
        vec[12] = '{OP_OR,  1'b1, 8'h80, 8'h01, 0, 0, 0, 1'b0, 8'h81, 3'b001};
        vec[13] = '{OP_SHR, 1'b1, 8'h80, 8'h07, 0, 0, 0, 1'b0, 8'h01, 3'b001};
        vec[14] = '{OP_SHR, 1'b1, 8'h80, 8'h08, 0, 0, 0, 1'b0, 8'h00, 3'b001};
        vec[15] = '{OP_SHL, 1'b1, 8'h03, 8'h07, 0, 0, 0, 1'b0, 8'h80, 3'b001};
        vec[16] = '{OP_DEC, 1'b1, 8'h00, 8'h00, 0, 0, 1, 1'b0, 8'hFF, 3'b001};
        vec[17] = '{opcode_t'(4'hF), 1'b1, 8'h12, 8'h34, 0, 0, 0, 1'b0, 8'h00, 3'b001};
        vec[18] = '{OP_SUB, 1'b1, 8'h10, 8'h20, 0, 0, 0, 1'b0, 8'hF0, 3'b101};

        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_opcode   = OP_ADD;
        cmd_flags_we = 1'b0;
        bus_in       = '0;
        bus_in_valid = 1'b0;
        res_ready    = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset res_valid", res_valid, 0);
        chk("reset bus_out", bus_out, 0);
        chk("reset flags", flags(), 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset cmd_ready", cmd_ready, 1);
        chk("post-reset res_valid", res_valid, 0);

        for (int i = 0; i < 19; i++) run_op($sformatf("vec%0d", i), vec[i]);

        // Abort in WAIT_B with A=0x12 latched and flags/bus_out non-zero.
        cmd_valid    = 1'b1;
        cmd_opcode   = OP_ADD;
        cmd_flags_we = 1'b1;
        @(negedge clk);
        cmd_valid    = 1'b0;
        bus_in_valid = 1'b1;
        bus_in       = 8'h12;
        @(negedge clk);
        bus_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort cmd_ready", cmd_ready, 1);
        chk("abort res_valid", res_valid, 0);
        chk("abort flags", flags(), 3'b000);
        chk("abort bus_out", bus_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort idle%0d res_valid", i), res_valid, 0);
            chk($sformatf("abort idle%0d cmd_ready", i), cmd_ready, 1);
        end
        run_op("after-abort", '{OP_ADD, 1'b1, 8'h7F, 8'h01, 0, 0, 0, 1'b0, 8'h80, 3'b001});

        chk("scoreboard drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
